// File: rtl/alu_pkg.sv
// Opcode encodings and helpers shared by the EX-stage ALU / mul-div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] ALU_ADD  = 5'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 5'd1;
  localparam logic [OPW-1:0] ALU_AND  = 5'd2;
  localparam logic [OPW-1:0] ALU_OR   = 5'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 5'd4;
  localparam logic [OPW-1:0] ALU_NOR  = 5'd5;
  localparam logic [OPW-1:0] ALU_SLL  = 5'd6;
  localparam logic [OPW-1:0] ALU_SRL  = 5'd7;
  localparam logic [OPW-1:0] ALU_SRA  = 5'd8;
  localparam logic [OPW-1:0] ALU_SLT  = 5'd9;
  localparam logic [OPW-1:0] ALU_MUL  = 5'd10;
  localparam logic [OPW-1:0] ALU_DIV  = 5'd11;
  localparam logic [OPW-1:0] ALU_MFHI = 5'd12;
  localparam logic [OPW-1:0] ALU_MFLO = 5'd13;
  localparam logic [OPW-1:0] ALU_MTHI = 5'd14;
  localparam logic [OPW-1:0] ALU_MTLO = 5'd15;

  // Opcodes that touch HI/LO or the mul/div engine (and so may have to wait on it).
  function automatic logic op_is_md(input logic [OPW-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_MTLO);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 shift-add multiplier / restoring divider working on operand magnitudes.
// Latency: one step per cycle with step=1; hi/lo show the sign-corrected result of the step in progress.
// Backpressure: none; the owner sequences start/step/last and samples hi/lo when done=1.
// Ports: clk, reset (async, active-high); start latches a/b/sgn/is_div; step advances one iteration;
//        last marks the final step; done = step & last; hi/lo = final result valid with done.
module md_iter_core
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic             is_div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // acc_q: partial product high half / partial remainder.
  // sh_q : multiplier being consumed LSB-first / dividend shifting out as quotient shifts in.
  // m_q  : multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc_q, sh_q, m_q, dvd_q;
  logic             div_q, neg_q_q, neg_r_q, bzero_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_nxt, sh_nxt;
  logic [WIDTH:0]   sum, rem_sh;
  logic             ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign sum    = {1'b0, acc_q} + ({1'b0, m_q} & {(WIDTH+1){sh_q[0]}});
  assign rem_sh = {acc_q, sh_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, m_q};

  always_comb begin
    acc_nxt = '0;
    sh_nxt  = '0;
    if (div_q) begin
      // A true difference is always < 2^WIDTH, so the truncated subtract is exact.
      acc_nxt = ge ? (rem_sh[WIDTH-1:0] - m_q) : rem_sh[WIDTH-1:0];
      sh_nxt  = {sh_q[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      sh_nxt  = {sum[0], sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi   = '0;
    lo   = '0;
    prod = {acc_nxt, sh_nxt};
    if (neg_q_q) prod = -prod;
    quo  = neg_q_q ? -sh_nxt  : sh_nxt;
    rem  = neg_r_q ? -acc_nxt : acc_nxt;   // remainder follows the dividend's sign
    if (div_q) begin
      if (bzero_q) begin
        hi = dvd_q;
        lo = '1;
      end else begin
        hi = rem;
        lo = quo;
      end
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

  assign done = step & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      dvd_q   <= '0;
      div_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bzero_q <= 1'b0;
    end else if (start) begin
      acc_q   <= '0;
      sh_q    <= is_div ? a_mag : b_mag;
      m_q     <= is_div ? b_mag : a_mag;
      dvd_q   <= a;
      div_q   <= is_div;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      bzero_q <= (b == '0);
    end else if (step) begin
      acc_q <= acc_nxt;
      sh_q  <= sh_nxt;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage unit: combinational ALU plus background multi-cycle MUL/DIV with HI/LO registers.
// Latency: ALU ops 0 cycles; MUL/DIV busy WIDTH cycles (MUL 1 cycle with ALU_FAST_MUL_EN defined).
// Backpressure: stall=1 only for HI/LO or mul/div opcodes (10..15) presented while busy.
// Ports: clk, reset (async, active-high), valid, ALUCtrl[4:0], Sign, in1, in2 -> out, zero, busy, stall.
// Build option: ALU_FAST_MUL_EN selects a single-cycle registered multiply; DIV is always iterative.
module alu_md_unit
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             stall
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q, cnt_load;
  logic [SHW-1:0]   shamt;
  logic             lt;
  logic             md_issue, mthi_wr, mtlo_wr, md_done, md_last;
  logic [WIDTH-1:0] core_hi, core_lo, res_hi, res_lo;

  // ---------------- ALU ----------------
  assign shamt = in1[SHW-1:0];
  assign lt    = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

  always_comb begin
    out = '0;
    case (ALUCtrl)
      ALU_ADD:  out = in1 + in2;
      ALU_SUB:  out = in1 - in2;
      ALU_AND:  out = in1 & in2;
      ALU_OR:   out = in1 | in2;
      ALU_XOR:  out = in1 ^ in2;
      ALU_NOR:  out = ~(in1 | in2);
      ALU_SLL:  out = in2 << shamt;
      ALU_SRL:  out = in2 >> shamt;
      ALU_SRA:  out = WIDTH'($signed(in2) >>> shamt);
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, lt};
      ALU_MFHI: out = hi_q;
      ALU_MFLO: out = lo_q;
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);

  // ---------------- control ----------------
  assign busy     = busy_q;
  assign stall    = valid & busy_q & op_is_md(ALUCtrl);
  assign md_issue = valid & ~stall & ((ALUCtrl == ALU_MUL) | (ALUCtrl == ALU_DIV));
  assign mthi_wr  = valid & ~stall & (ALUCtrl == ALU_MTHI);
  assign mtlo_wr  = valid & ~stall & (ALUCtrl == ALU_MTLO);
  assign md_last  = (cnt_q == CW'(1));

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (md_issue),
    .step   (busy_q),
    .last   (md_last),
    .is_div (ALUCtrl == ALU_DIV),
    .sgn    (Sign),
    .a      (in1),
    .b      (in2),
    .done   (md_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

`ifdef ALU_FAST_MUL_EN
  // MUL: operands registered at issue, product formed in one step on the next edge.
  logic [WIDTH-1:0]   fa_q, fb_q;
  logic               fsgn_q, fmul_q;
  logic [2*WIDTH-1:0] fprod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa_q   <= '0;
      fb_q   <= '0;
      fsgn_q <= 1'b0;
      fmul_q <= 1'b0;
    end else if (md_issue) begin
      fa_q   <= in1;
      fb_q   <= in2;
      fsgn_q <= Sign;
      fmul_q <= (ALUCtrl == ALU_MUL);
    end
  end

  // Sign-extended operands give the correct signed product modulo 2^(2*WIDTH).
  assign fprod    = {{WIDTH{fsgn_q & fa_q[WIDTH-1]}}, fa_q} *
                    {{WIDTH{fsgn_q & fb_q[WIDTH-1]}}, fb_q};
  assign cnt_load = (ALUCtrl == ALU_MUL) ? CW'(1) : CW'(WIDTH);
  assign res_hi   = fmul_q ? fprod[2*WIDTH-1:WIDTH] : core_hi;
  assign res_lo   = fmul_q ? fprod[WIDTH-1:0]       : core_lo;
`else
  assign cnt_load = CW'(WIDTH);
  assign res_hi   = core_hi;
  assign res_lo   = core_lo;
`endif

  // MTHI/MTLO cannot coincide with completion: they stall while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (md_issue) begin
        busy_q <= 1'b1;
        cnt_q  <= cnt_load;
      end else if (busy_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (md_done) begin
          busy_q <= 1'b0;
          hi_q   <= res_hi;
          lo_q   <= res_lo;
        end
      end
      if (mthi_wr) hi_q <= in1;
      if (mtlo_wr) lo_q <= in1;
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: ALU vectors, SLT, MUL/DIV results and timing, stall, reset abort.
// Inputs change on the falling edge; outputs are sampled 1 ns after that.
// Ends with a single summary line.
module tb_alu_md_unit;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [4:0]   ALUCtrl;
  logic         Sign;
  logic [W-1:0] in1, in2, out;
  logic         zero, busy, stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .ALUCtrl (ALUCtrl),
    .Sign    (Sign),
    .in1     (in1),
    .in2     (in2),
    .out     (out),
    .zero    (zero),
    .busy    (busy),
    .stall   (stall)
  );

  task automatic drive(input logic v, input logic [4:0] op, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    valid = v; ALUCtrl = op; Sign = s; in1 = a; in2 = b;
  endtask

  // Issue one MUL/DIV, count busy cycles, then read HI and LO back.
  task automatic run_md(input logic [4:0] op, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int cyc,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    @(negedge clk); drive(1'b1, op, s, a, b);
    @(negedge clk); drive(1'b0, ALU_ADD, 1'b0, '0, '0);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    drive(1'b1, ALU_MFHI, 1'b0, '0, '0);
    #1 hi = out;
    ALUCtrl = ALU_MFLO;
    #1 lo = out;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, ALU_ADD, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    drive(1'b1, ALU_MFHI, 1'b0, '0, '0);
    #1;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", out); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    ALUCtrl = ALU_MFLO;
    #1;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", out); end
    drive(1'b1, ALU_ADD, 1'b0, 32'd3, 32'd4);
    #1;
    checks++; if (out !== 32'd7) begin errors++; $display("FAIL reset_comb_add: got %h want 7", out); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, ALU_ADD, 1'b0, '0, '0);
  endtask

  task automatic test_alu();
    logic [4:0]   ops[12] = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_AND, ALU_OR, ALU_XOR,
                              ALU_NOR, ALU_SLL, ALU_SRL, ALU_SUB, 5'd20, ALU_MUL};
    logic [W-1:0] as[12]  = '{32'h7FFFFFFF, 32'd5, 32'd4, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                              32'h0, 32'h24, 32'h1F, 32'h0, 32'd5, 32'd3};
    logic [W-1:0] bs[12]  = '{32'h1, 32'd5, 32'h80000000, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F,
                              32'h0, 32'h1, 32'h80000000, 32'h1, 32'd5, 32'd4};
    logic [W-1:0] ex[12]  = '{32'h80000000, 32'h0, 32'hF8000000, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F,
                              32'hFFFFFFFF, 32'h10, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      // MUL row only observes the combinational out=0, so keep it from issuing.
      drive(ops[i] != ALU_MUL, ops[i], 1'b0, as[i], bs[i]);
      #1;
      checks++;
      if (out !== ex[i]) begin errors++; $display("FAIL alu_out[%0d]: got %h want %h", i, out, ex[i]); end
      checks++;
      if (zero !== (ex[i] == '0)) begin errors++; $display("FAIL alu_zero[%0d]: got %b want %b", i, zero, ex[i] == '0); end
    end
    valid = 1'b0;
  endtask

  task automatic test_slt();
    logic         ss[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] as[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1};
    logic [W-1:0] bs[4] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] ex[4] = '{32'h1, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, ALU_SLT, ss[i], as[i], bs[i]);
      #1;
      checks++;
      if (out !== ex[i]) begin errors++; $display("FAIL slt[%0d]: got %h want %h", i, out, ex[i]); end
    end
    valid = 1'b0;
  endtask

  task automatic test_mul();
    int cyc; logic [W-1:0] hi, lo;
    run_md(ALU_MUL, 1'b1, 32'hFFFFFFFD, 32'd7, cyc, hi, lo);
    checks++; if (cyc !== MUL_CYC) begin errors++; $display("FAIL mul_busy_cycles: got %0d want %0d", cyc, MUL_CYC); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_s_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_s_lo: got %h want ffffffeb", lo); end
    run_md(ALU_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, hi, lo);
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_u_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mul_u_lo: got %h want 00000001", lo); end
    run_md(ALU_MUL, 1'b1, 32'h80000000, 32'h80000000, cyc, hi, lo);
    checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mul_min_hi: got %h want 40000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mul_min_lo: got %h want 0", lo); end
  endtask

  task automatic test_div();
    logic         ss[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] as[6]  = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'd100, 32'd7, 32'hFFFFFFF9};
    logic [W-1:0] bs[6]  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd0};
    logic [W-1:0] elo[6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [W-1:0] ehi[6] = '{32'hFFFFFFFF, 32'd9, 32'h0, 32'd2, 32'd1, 32'hFFFFFFF9};
    int cyc; logic [W-1:0] hi, lo;
    for (int i = 0; i < 6; i++) begin
      run_md(ALU_DIV, ss[i], as[i], bs[i], cyc, hi, lo);
      checks++; if (cyc !== W) begin errors++; $display("FAIL div_cycles[%0d]: got %0d want %0d", i, cyc, W); end
      checks++; if (lo !== elo[i]) begin errors++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, elo[i]); end
      checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, ehi[i]); end
    end
  endtask

  task automatic test_stall();
    int n = 0; int bad = 0;
    @(negedge clk); drive(1'b1, ALU_DIV, 1'b0, 32'd84, 32'd2);
    @(negedge clk); drive(1'b1, ALU_MFLO, 1'b0, '0, '0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_mflo_first: got %b want 1", stall); end
    @(negedge clk); drive(1'b1, ALU_ADD, 1'b0, 32'd2, 32'd3);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_add_busy: got %b want 0", stall); end
    checks++; if (out !== 32'd5) begin errors++; $display("FAIL add_during_busy: got %h want 5", out); end
    @(negedge clk); drive(1'b1, ALU_MFLO, 1'b0, '0, '0);
    while (busy && n < 200) begin
      #1 if (stall !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_held: got %0d unstalled cycles want 0", bad); end
    checks++; if (n !== W - 2) begin errors++; $display("FAIL stall_length: got %0d want %0d", n, W - 2); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stall); end
    checks++; if (out !== 32'd42) begin errors++; $display("FAIL mflo_after_busy: got %h want 2a", out); end
    ALUCtrl = ALU_MFHI;
    #1;
    checks++; if (out !== 32'd0) begin errors++; $display("FAIL mfhi_after_busy: got %h want 0", out); end
    valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0; int cyc = 0; logic [W-1:0] hi, lo;
    @(negedge clk); drive(1'b1, ALU_DIV, 1'b0, 32'd100, 32'd7);
    @(negedge clk); drive(1'b0, ALU_ADD, 1'b0, '0, '0);
    while (busy && n < 200) begin n++; @(negedge clk); end
    // First cycle with busy low: a new MUL must be accepted immediately.
    drive(1'b1, ALU_MUL, 1'b0, 32'd6, 32'd7);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_issue_stall: got %b want 0", stall); end
    @(negedge clk); drive(1'b0, ALU_ADD, 1'b0, '0, '0);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
    drive(1'b1, ALU_MFHI, 1'b0, '0, '0);
    #1 hi = out;
    ALUCtrl = ALU_MFLO;
    #1 lo = out;
    valid = 1'b0;
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_lo: got %h want 2a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_hi: got %h want 0", hi); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, ALU_MTHI, 1'b0, 32'hABCD, '0);
    @(negedge clk); drive(1'b1, ALU_DIV, 1'b0, 32'd1000, 32'd3);
    @(negedge clk); drive(1'b0, ALU_ADD, 1'b0, '0, '0);
    repeat (W - 10) @(negedge clk);     // count now at 10
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
    reset = 1'b1;
    drive(1'b1, ALU_MFLO, 1'b0, '0, '0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", out); end
    ALUCtrl = ALU_MFHI;
    #1;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", out); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, ALU_MTLO, 1'b0, 32'h1234, '0);
    @(negedge clk); drive(1'b1, ALU_MFLO, 1'b0, '0, '0);
    #1;
    checks++; if (out !== 32'h1234) begin errors++; $display("FAIL mtlo_mflo: got %h want 1234", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after_busy: got %b want 0", busy); end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_slt();
    test_mul();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
